// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the per-slot DRAM arbiter.
package dram_arb_pkg;

  localparam int unsigned ADDR_W = 21;

  localparam logic [1:0] BSEL_LO = 2'b01;
  localparam logic [1:0] BSEL_HI = 2'b10;
  localparam logic [1:0] BSEL_W  = 2'b11;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_VID,
    OWN_CPU,
    OWN_DMA
  } owner_t;

endpackage

// File: rtl/dram_arb_if.sv
// Request/return and DRAM-controller signals shared by the arbiter and its clients.
interface dram_arb_if;
  import dram_arb_pkg::*;

  logic              c0, c1, c2, c3;

  logic              cpu_req;
  logic              cpu_rnw;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_wrbsel;
  logic [7:0]        cpu_wrdata;
  logic              cpu_next;
  logic              cpu_strobe;
  logic              cpu_latch;
  logic [15:0]       cpu_rddata;

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_next;
  logic              vid_strobe;
  logic [15:0]       vid_rddata;

  logic              dma_req;
  logic              dma_rnw;
  logic [ADDR_W-1:0] dma_addr;
  logic [15:0]       dma_wrdata;
  logic              dma_next;
  logic              dma_strobe;
  logic [15:0]       dma_rddata;

  logic              dram_req;
  logic              dram_rnw;
  logic [ADDR_W-1:0] dram_addr;
  logic [1:0]        dram_bsel;
  logic [15:0]       dram_wrdata;
  logic [15:0]       dram_rddata;

  // Clients and the DRAM controller side.
  modport master (
    output c0, c1, c2, c3,
    output cpu_req, cpu_rnw, cpu_addr, cpu_wrbsel, cpu_wrdata,
    input  cpu_next, cpu_strobe, cpu_latch, cpu_rddata,
    output vid_req, vid_addr,
    input  vid_next, vid_strobe, vid_rddata,
    output dma_req, dma_rnw, dma_addr, dma_wrdata,
    input  dma_next, dma_strobe, dma_rddata,
    input  dram_req, dram_rnw, dram_addr, dram_bsel, dram_wrdata,
    output dram_rddata
  );

  // The arbiter.
  modport slave (
    input  c0, c1, c2, c3,
    input  cpu_req, cpu_rnw, cpu_addr, cpu_wrbsel, cpu_wrdata,
    output cpu_next, cpu_strobe, cpu_latch, cpu_rddata,
    input  vid_req, vid_addr,
    output vid_next, vid_strobe, vid_rddata,
    input  dma_req, dma_rnw, dma_addr, dma_wrdata,
    output dma_next, dma_strobe, dma_rddata,
    output dram_req, dram_rnw, dram_addr, dram_bsel, dram_wrdata,
    input  dram_rddata
  );

endinterface

// File: rtl/dma_starve_cnt.sv
// Counts consecutive slots lost by a requesting DMA; saturates at MaxWait and raises force_o.
module dma_starve_cnt #(
  parameter int unsigned MaxWait = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_i,
  input  logic       dma_req_i,
  input  logic       dma_win_i,
  output logic       force_o,
  output logic [3:0] cnt_o
);

  localparam logic [3:0] MaxCnt = 4'(MaxWait);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (sample_i) begin
      if (dma_req_i && !dma_win_i) begin
        cnt_d = (cnt_q == MaxCnt) ? cnt_q : cnt_q + 4'd1;
      end else begin
        cnt_d = 4'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_o = dma_req_i && (cnt_q == MaxCnt);
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/dram_arb.sv
// Grants each 4-clock DRAM slot to video, CPU or DMA (video > CPU > DMA, with a DMA
// starvation guard) and returns read data/strobes to the winner of the previous slot.
module dram_arb
  import dram_arb_pkg::*;
#(
  parameter int unsigned DMA_MAXWAIT = 8
) (
  input logic       clk,
  input logic       rst,
  dram_arb_if.slave bus
);

  owner_t            owner_q, owner_d, win;
  logic              rnw_q, rnw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        bsel_q, bsel_d;
  logic [15:0]       wrdata_q, wrdata_d;

  logic [15:0] cpu_rd_q, cpu_rd_d, vid_rd_q, vid_rd_d, dma_rd_q, dma_rd_d;
  logic        cpu_stb_q, cpu_stb_d, vid_stb_q, vid_stb_d, dma_stb_q, dma_stb_d;
  logic        latch_q, latch_d;

  logic        dma_force;
  logic [3:0]  wait_cnt;
  logic        cpu_cap, vid_cap, dma_done, cpu_wr_grant;

  // Only c3 is a sampling point; the other phase strobes are informational here.
  logic unused_phase;
  assign unused_phase = bus.c0 ^ bus.c1 ^ bus.c2;

  dma_starve_cnt #(
    .MaxWait(DMA_MAXWAIT)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .sample_i (bus.c3),
    .dma_req_i(bus.dma_req),
    .dma_win_i(win == OWN_DMA),
    .force_o  (dma_force),
    .cnt_o    (wait_cnt)
  );

  assign bus.vid_next = bus.vid_req;
  assign bus.cpu_next = !bus.vid_req && !dma_force;
  assign bus.dma_next = bus.dma_req && !bus.vid_req && (dma_force || !bus.cpu_req);

  always_comb begin
    win = OWN_NONE;
    if (bus.vid_req) begin
      win = OWN_VID;
    end else if (bus.cpu_req && bus.cpu_next) begin
      win = OWN_CPU;
    end else if (bus.dma_next) begin
      win = OWN_DMA;
    end
  end

  // Slot ownership and request fields, latched at c3 for the following slot.
  always_comb begin
    owner_d  = owner_q;
    rnw_d    = rnw_q;
    addr_d   = addr_q;
    bsel_d   = bsel_q;
    wrdata_d = wrdata_q;
    if (bus.c3) begin
      owner_d = win;
      case (win)
        OWN_VID: begin
          rnw_d    = 1'b1;
          addr_d   = bus.vid_addr;
          bsel_d   = BSEL_W;
          wrdata_d = '0;
        end
        OWN_CPU: begin
          rnw_d    = bus.cpu_rnw;
          addr_d   = bus.cpu_addr;
          bsel_d   = bus.cpu_rnw ? BSEL_W : (bus.cpu_wrbsel ? BSEL_HI : BSEL_LO);
          wrdata_d = {bus.cpu_wrdata, bus.cpu_wrdata};
        end
        OWN_DMA: begin
          rnw_d    = bus.dma_rnw;
          addr_d   = bus.dma_addr;
          bsel_d   = BSEL_W;
          wrdata_d = bus.dma_wrdata;
        end
        default: begin
          rnw_d    = 1'b1;
          addr_d   = '0;
          bsel_d   = BSEL_W;
          wrdata_d = '0;
        end
      endcase
    end
  end

  // Return path for the slot that is finishing at this c3.
  always_comb begin
    cpu_cap      = bus.c3 && (owner_q == OWN_CPU) && rnw_q;
    vid_cap      = bus.c3 && (owner_q == OWN_VID);
    dma_done     = bus.c3 && (owner_q == OWN_DMA);
    cpu_wr_grant = (win == OWN_CPU) && !bus.cpu_rnw;

    cpu_stb_d = cpu_cap;
    vid_stb_d = vid_cap;
    dma_stb_d = dma_done;
    cpu_rd_d  = cpu_cap ? bus.dram_rddata : cpu_rd_q;
    vid_rd_d  = vid_cap ? bus.dram_rddata : vid_rd_q;
    dma_rd_d  = (dma_done && rnw_q) ? bus.dram_rddata : dma_rd_q;

    // A write granted in the same slot makes the just-read word potentially stale.
    latch_d = latch_q;
    if (bus.c3) begin
      latch_d = cpu_cap && !cpu_wr_grant;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q   <= OWN_NONE;
      rnw_q     <= 1'b1;
      addr_q    <= '0;
      bsel_q    <= BSEL_W;
      wrdata_q  <= '0;
      cpu_rd_q  <= '0;
      vid_rd_q  <= '0;
      dma_rd_q  <= '0;
      cpu_stb_q <= 1'b0;
      vid_stb_q <= 1'b0;
      dma_stb_q <= 1'b0;
      latch_q   <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      rnw_q     <= rnw_d;
      addr_q    <= addr_d;
      bsel_q    <= bsel_d;
      wrdata_q  <= wrdata_d;
      cpu_rd_q  <= cpu_rd_d;
      vid_rd_q  <= vid_rd_d;
      dma_rd_q  <= dma_rd_d;
      cpu_stb_q <= cpu_stb_d;
      vid_stb_q <= vid_stb_d;
      dma_stb_q <= dma_stb_d;
      latch_q   <= latch_d;
    end
  end

  assign bus.dram_req    = (owner_q != OWN_NONE);
  assign bus.dram_rnw    = rnw_q;
  assign bus.dram_addr   = addr_q;
  assign bus.dram_bsel   = bsel_q;
  assign bus.dram_wrdata = wrdata_q;

  assign bus.cpu_strobe = cpu_stb_q;
  assign bus.cpu_latch  = latch_q;
  assign bus.cpu_rddata = cpu_rd_q;
  assign bus.vid_strobe = vid_stb_q;
  assign bus.vid_rddata = vid_rd_q;
  assign bus.dma_strobe = dma_stb_q;
  assign bus.dma_rddata = dma_rd_q;

endmodule

// File: doc/dram_arb.md
# dram_arb

Per-slot DRAM arbiter sitting directly downstream of the Z80 memory manager. It grants each 4-clock DRAM cycle (phases c0..c3) to video, CPU or DMA. It drives the shared DRAM controller port and returns the handshake signals the memory manager consumes: `cpu_next`, `cpu_strobe`, `cpu_latch` and `cpu_rddata`. Priority is video > CPU > DMA, with a starvation guard that forces a DMA slot after a bounded number of losses.

## Interface
- `DMA_MAXWAIT`, default 8: consecutive lost slots with `dma_req` high before DMA is forced ahead of the CPU; legal range 1..15.
- `clk` in 1: system clock; single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `c0`, `c1`, `c2`, `c3` in 1 each: one-hot phase strobes; each is 1 clk wide; c0 starts a DRAM cycle.
- `cpu_req` in 1: CPU slot request, sampled at c3.
- `cpu_rnw` in 1: 1 = read, 0 = write.
- `cpu_addr` in 21: word address.
- `cpu_wrbsel` in 1: byte select; 0 = low byte, 1 = high byte.
- `cpu_wrdata` in 8: write byte.
- `cpu_next` out 1: combinational; the slot starting at the next c0 is available to the CPU.
- `cpu_strobe` out 1: 1-clk pulse; `cpu_rddata` has just been updated by a CPU read.
- `cpu_latch` out 1: `cpu_rddata` is fresh; the memory manager selects it over its cache.
- `cpu_rddata` out 16: registered read word.
- `vid_req` in 1: video fetch request.
- `vid_addr` in 21: video word address.
- `vid_next` out 1: combinational; equals `vid_req`.
- `vid_strobe` out 1: 1-clk pulse; `vid_rddata` is valid.
- `vid_rddata` out 16: registered read word for video.
- `dma_req` in 1: DMA slot request.
- `dma_rnw` in 1: 1 = read, 0 = write.
- `dma_addr` in 21: DMA word address.
- `dma_wrdata` in 16: DMA write word.
- `dma_next` out 1: combinational; DMA wins the next slot.
- `dma_strobe` out 1: 1-clk pulse; `dma_rddata` valid, or DMA write completed.
- `dma_rddata` out 16: registered read word for DMA.
- `dram_req` out 1: a slot is active.
- `dram_rnw` out 1: 1 = read, 0 = write.
- `dram_addr` out 21: word address to the DRAM controller.
- `dram_bsel` out 2: byte enables.
- `dram_wrdata` out 16: write word.
- `dram_rddata` in 16: valid during c3 of a read slot.

## Operation
- Decision is combinational and evaluated every clock.
  - `vid_next` = `vid_req`.
  - `force` = `dma_req` and (`wait_cnt` == `DMA_MAXWAIT`).
  - `cpu_next` = !`vid_req` and !`force`.
  - `dma_next` = `dma_req` and !`vid_req` and (`force` or !`cpu_req`).
- At c3 the winner is registered into `owner`, one of NONE/VID/CPU/DMA, together with its request fields. The CPU wins only if `cpu_req` and `cpu_next` are both high at c3.
- The registered fields drive the `dram_*` outputs for the whole next cycle (c0..c3).
  - `dram_req` = (`owner` != NONE).
  - CPU write: `dram_bsel` = `cpu_wrbsel` ? 2'b10 : 2'b01; `dram_wrdata` = {`cpu_wrdata`, `cpu_wrdata`}.
  - All reads, and DMA/video accesses: `dram_bsel` = 2'b11.
- Starvation counter `wait_cnt`, 4 bits:
  - At c3, if `dma_req` is high and DMA loses, increment, saturating at `DMA_MAXWAIT`.
  - At c3, if DMA wins or `dma_req` is low, clear to 0.
- Read return: at c3 of an owned read slot, `dram_rddata` is captured into the owner's `*_rddata` register. The owner's strobe is high during the following clk, which coincides with the next c0.
- CPU writes produce no `cpu_strobe`. DMA writes pulse `dma_strobe` at the same point a read would.
- `cpu_latch` rises together with `cpu_strobe` and falls after the next c3, so it is high for 4 clk. It is cleared immediately by a CPU write grant.

## Timing
- Slot latency: request sampled at c3 of cycle N-1; DRAM access in cycle N; strobe at c0 of cycle N+1. Read latency from grant to strobe is 5 clk.
- Back-to-back grants to the same master are allowed every slot. Strobes are then periodic with a 4-clk spacing.
- Simultaneous `vid_req`, `cpu_req` and `dma_req` with `force` high: video wins, DMA wins the next free slot, and the CPU waits.
- `cpu_req` dropped between c3 samples has no effect. Only c3 sampling counts.
- `rst` asserted at any phase clears all of the following on the next edge:
  - `owner` = NONE, `wait_cnt` = 0;
  - all strobes, `cpu_latch` and `dram_req` = 0;
  - all `*_rddata` = 0.
  - An in-flight slot is abandoned with no strobe.
- No phase strobe high: state holds and nothing is sampled.

## Structure
- Package `dram_arb_pkg` holds:
  - the `owner_t` enum (OWN_NONE, OWN_VID, OWN_CPU, OWN_DMA);
  - `BSEL_LO` = 2'b01, `BSEL_HI` = 2'b10, `BSEL_W` = 2'b11;
  - the address width constant, 21.
- One sub-module: `dma_starve_cnt`, the saturating wait counter with `force` output.

## Test plan
- CPU read alone: `cpu_req`=1, `cpu_rnw`=1, `cpu_addr`=21'h012345 at c3 -> `dram_addr`=21'h012345 and `dram_bsel`=2'b11 during c0..c3; `dram_rddata`=16'hBEEF at c3 -> `cpu_strobe`=1 and `cpu_rddata`=16'hBEEF at the next c0; `cpu_latch` high for 4 clk.
- CPU high-byte write: `cpu_wrbsel`=1, `cpu_wrdata`=8'h5A -> `dram_bsel`=2'b10, `dram_wrdata`=16'h5A5A, no `cpu_strobe`.
- Video priority: `vid_req` and `cpu_req` both held -> `cpu_next`=0 every slot, all slots go to VID, `vid_strobe` every 4 clk.
- Starvation with `DMA_MAXWAIT`=3: `cpu_req` and `dma_req` held -> three CPU slots, then one DMA slot with `cpu_next`=0 at that c3, then the pattern repeats.
- Reset mid-slot: `rst` pulsed at c1 of a CPU read -> no `cpu_strobe`, `dram_req`=0 and `cpu_rddata`=0 the next clk.
- Idle: no requests -> `dram_req`=0, `wait_cnt`=0, `cpu_next`=1.
